// File: rtl/traffic_pkg.sv
// Phase codes shared by the traffic-light controller and its timer.
package traffic_pkg;
  typedef enum logic [2:0] {
    PH_ALLRED = 3'd0,
    PH_GREEN  = 3'd1,
    PH_YELLOW = 3'd2,
    PH_WALK   = 3'd3,
    PH_FLASH  = 3'd4
  } phase_e;
endpackage

// File: rtl/phase_timer.sv
// Per-phase up-counter with a terminal compare against a runtime limit.
module phase_timer #(
  parameter int CNT_W = 26
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             enable,
  input  logic [CNT_W-1:0] limit,
  output logic [CNT_W-1:0] cnt,
  output logic             done
);
  always_ff @(posedge clk) begin
    if (rst)         cnt <= '0;
    else if (clear)  cnt <= '0;
    else if (enable) cnt <= cnt + CNT_W'(1);
  end

  assign done = (cnt == limit);
endmodule

// File: rtl/traffic_light_ctrl.sv
// Round-robin multi-direction traffic-light FSM with pedestrian walk phase,
// flashing-yellow night mode and run/hold enable.
module traffic_light_ctrl
  import traffic_pkg::*;
#(
  parameter int NUM_DIRS    = 2,
  parameter int CNT_W       = 26,
  parameter int T_GREEN     = 50_000_000,
  parameter int T_GREEN_MIN = 15_000_000,
  parameter int T_YELLOW    = 25_000_000,
  parameter int T_ALLRED    = 5_000_000,
  parameter int T_WALK      = 25_000_000,
  parameter int T_FLASH     = 25_000_000,
  localparam int DIR_W      = $clog2(NUM_DIRS)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                enable,
  input  logic                night_mode,
  input  logic                ped_req,
  output logic [NUM_DIRS-1:0] red,
  output logic [NUM_DIRS-1:0] yellow,
  output logic [NUM_DIRS-1:0] green,
  output logic                walk,
  output logic [DIR_W-1:0]    cur_dir,
  output logic [2:0]          phase
);
  phase_e             state;
  logic               ped_pending;
  logic               flash_on;
  logic [CNT_W-1:0]   cnt;
  logic [CNT_W-1:0]   limit;
  logic               done;
  logic               green_cut;
  logic               exit_now;
  logic               walk_entry;
  logic [DIR_W-1:0]   next_dir;

  always_comb begin
    limit = CNT_W'(T_ALLRED - 1);
    case (state)
      PH_GREEN:  limit = CNT_W'(T_GREEN - 1);
      PH_YELLOW: limit = CNT_W'(T_YELLOW - 1);
      PH_WALK:   limit = CNT_W'(T_WALK - 1);
      PH_FLASH:  limit = CNT_W'(T_FLASH - 1);
      default:   limit = CNT_W'(T_ALLRED - 1);
    endcase
  end

  // A waiting pedestrian cuts green short once the minimum green has elapsed.
  assign green_cut  = (state == PH_GREEN) && ped_pending &&
                      (cnt >= CNT_W'(T_GREEN_MIN - 1));
  assign exit_now   = done || green_cut;
  assign walk_entry = enable && done && (state == PH_ALLRED) &&
                      !night_mode && ped_pending;
  assign next_dir   = (cur_dir == DIR_W'(NUM_DIRS - 1)) ? '0 : cur_dir + DIR_W'(1);

  phase_timer #(.CNT_W(CNT_W)) u_timer (
    .clk    (clk),
    .rst    (rst),
    .clear  (enable && exit_now),
    .enable (enable),
    .limit  (limit),
    .cnt    (cnt),
    .done   (done)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= PH_ALLRED;
      cur_dir  <= DIR_W'(NUM_DIRS - 1);
      flash_on <= 1'b0;
    end else if (enable && exit_now) begin
      case (state)
        PH_ALLRED: begin
          if (night_mode) begin
            state    <= PH_FLASH;
            flash_on <= 1'b1;
          end else if (ped_pending) begin
            state <= PH_WALK;
          end else begin
            state   <= PH_GREEN;
            cur_dir <= next_dir;
          end
        end
        PH_GREEN:  state <= PH_YELLOW;
        PH_YELLOW: state <= PH_ALLRED;
        PH_WALK: begin
          state   <= PH_GREEN;
          cur_dir <= next_dir;
        end
        PH_FLASH: begin
          if (night_mode) flash_on <= ~flash_on;
          else            state    <= PH_ALLRED;
        end
        default: state <= PH_ALLRED;
      endcase
    end
  end

  // Requests latch even while held; a new request wins over the WALK clear.
  always_ff @(posedge clk) begin
    if (rst)             ped_pending <= 1'b0;
    else if (ped_req)    ped_pending <= 1'b1;
    else if (walk_entry) ped_pending <= 1'b0;
  end

  for (genvar d = 0; d < NUM_DIRS; d++) begin : g_dir
    logic sel;
    assign sel       = (cur_dir == DIR_W'(d));
    assign green[d]  = (state == PH_GREEN) && sel;
    assign yellow[d] = ((state == PH_YELLOW) && sel) || ((state == PH_FLASH) && flash_on);
    assign red[d]    = (state != PH_FLASH) && !green[d] && !yellow[d];
  end

  assign walk  = (state == PH_WALK);
  assign phase = state;
endmodule

// File: tb/tb_traffic_light_ctrl.sv
// Directed vector table plus randomized run against a countdown-based reference model.
module tb_traffic_light_ctrl;
  localparam int N = 3, TG = 8, TGM = 3, TY = 3, TAR = 2, TW = 4, TF = 2;

  logic clk = 0, rst = 1, enable = 1, night_mode = 0, ped_req = 0;
  logic [N-1:0] red, yellow, green;
  logic walk;
  logic [1:0] cur_dir;
  logic [2:0] phase;
  int n_chk = 0, n_fail = 0;

  traffic_light_ctrl #(.NUM_DIRS(N), .CNT_W(4), .T_GREEN(TG), .T_GREEN_MIN(TGM),
    .T_YELLOW(TY), .T_ALLRED(TAR), .T_WALK(TW), .T_FLASH(TF)) dut (
    .clk(clk), .rst(rst), .enable(enable), .night_mode(night_mode), .ped_req(ped_req),
    .red(red), .yellow(yellow), .green(green), .walk(walk), .cur_dir(cur_dir), .phase(phase));

  always #5 clk = ~clk;

  wire [14:0] obs = {red, yellow, green, walk, cur_dir, phase};

  typedef struct {
    string name; logic r_i, e_i, n_i, p_i; int n;
    logic [2:0] r, y, g; logic w; logic [1:0] d; logic [2:0] ph;
  } seg_t;
  seg_t tbl[$];

  function automatic void add(string name, logic r_i, e_i, n_i, p_i, int n,
                              logic [2:0] r, y, g, logic w, logic [1:0] d, logic [2:0] ph);
    seg_t s;
    s.name = name; s.r_i = r_i; s.e_i = e_i; s.n_i = n_i; s.p_i = p_i; s.n = n;
    s.r = r; s.y = y; s.g = g; s.w = w; s.d = d; s.ph = ph;
    tbl.push_back(s);
  endfunction

  // Apply inputs for n edges, checking all outputs after each edge.
  task automatic seg(string name, logic r_i, e_i, n_i, p_i, int n,
                     logic [2:0] r, y, g, logic w, logic [1:0] d, logic [2:0] ph);
    logic [14:0] exp;
    exp = {r, y, g, w, d, ph};
    for (int i = 0; i < n; i++) begin
      rst = r_i; enable = e_i; night_mode = n_i; ped_req = p_i;
      @(posedge clk); #1;
      n_chk++;
      if (obs !== exp) begin
        n_fail++;
        $display("FAIL %s cyc%0d: got r=%b y=%b g=%b w=%b dir=%0d ph=%0d, want r=%b y=%b g=%b w=%b dir=%0d ph=%0d",
                 name, i, red, yellow, green, walk, cur_dir, phase, r, y, g, w, d, ph);
      end
    end
  endtask

  // Reference model: remaining-time countdown per phase, phase as plain int.
  int m_ph, m_left, m_el, m_dir;
  bit m_pend, m_flash;

  function automatic int dur(int ph);
    case (ph)
      1: return TG; 2: return TY; 3: return TW; 4: return TF; default: return TAR;
    endcase
  endfunction

  function automatic void enter(int ph);
    m_ph = ph; m_left = dur(ph); m_el = 0;
  endfunction

  function automatic void model_step(bit r_i, e_i, n_i, p_i);
    bit p, np, fin;
    if (r_i) begin
      enter(0); m_dir = N - 1; m_pend = 0; m_flash = 0;
      return;
    end
    p = m_pend; np = m_pend | p_i;
    if (e_i) begin
      fin = (m_left == 1) || (m_ph == 1 && p && m_el + 1 >= TGM);
      if (!fin) begin
        m_left--; m_el++;
      end else begin
        case (m_ph)
          0: if (n_i) begin enter(4); m_flash = 1; end
             else if (p) begin enter(3); np = p_i; end
             else begin enter(1); m_dir = (m_dir + 1) % N; end
          1: enter(2);
          2: enter(0);
          3: begin enter(1); m_dir = (m_dir + 1) % N; end
          default: if (n_i) begin enter(4); m_flash = !m_flash; end else enter(0);
        endcase
      end
    end
    m_pend = np;
  endfunction

  function automatic logic [14:0] model_obs();
    logic [2:0] r, y, g; logic w;
    r = '0; y = '0; g = '0; w = 0;
    case (m_ph)
      0: r = '1;
      1: begin g = 3'(1 << m_dir); r = ~g; end
      2: begin y = 3'(1 << m_dir); r = ~y; end
      3: begin r = '1; w = 1; end
      default: y = m_flash ? 3'b111 : 3'b000;
    endcase
    return {r, y, g, w, 2'(m_dir), 3'(m_ph)};
  endfunction

  initial begin
    // Reset release, full round-robin wrap, then pedestrian cut-off.
    add("reset",  1,1,0,0, 1, 3'b111,3'b000,3'b000,0,2,0);
    add("allred", 0,1,0,0, 1, 3'b111,3'b000,3'b000,0,2,0);
    add("g0",     0,1,0,0, 8, 3'b110,3'b000,3'b001,0,0,1);
    add("y0",     0,1,0,0, 3, 3'b110,3'b001,3'b000,0,0,2);
    add("ar0",    0,1,0,0, 2, 3'b111,3'b000,3'b000,0,0,0);
    add("g1",     0,1,0,0, 8, 3'b101,3'b000,3'b010,0,1,1);
    add("y1",     0,1,0,0, 3, 3'b101,3'b010,3'b000,0,1,2);
    add("ar1",    0,1,0,0, 2, 3'b111,3'b000,3'b000,0,1,0);
    add("g2",     0,1,0,0, 8, 3'b011,3'b000,3'b100,0,2,1);
    add("y2",     0,1,0,0, 3, 3'b011,3'b100,3'b000,0,2,2);
    add("ar2",    0,1,0,0, 2, 3'b111,3'b000,3'b000,0,2,0);
    add("wrap",   0,1,0,0, 1, 3'b110,3'b000,3'b001,0,0,1);
    add("gped_a", 0,1,0,0, 1, 3'b110,3'b000,3'b001,0,0,1);
    add("gped_b", 0,1,0,1, 1, 3'b110,3'b000,3'b001,0,0,1);
    add("ycut",   0,1,0,0, 3, 3'b110,3'b001,3'b000,0,0,2);
    add("arp",    0,1,0,0, 2, 3'b111,3'b000,3'b000,0,0,0);
    add("walk",   0,1,0,0, 4, 3'b111,3'b000,3'b000,1,0,3);
    add("gafter", 0,1,0,0, 8, 3'b101,3'b000,3'b010,0,1,1);
    add("yafter", 0,1,0,0, 1, 3'b101,3'b010,3'b000,0,1,2);
    foreach (tbl[i])
      seg(tbl[i].name, tbl[i].r_i, tbl[i].e_i, tbl[i].n_i, tbl[i].p_i, tbl[i].n,
          tbl[i].r, tbl[i].y, tbl[i].g, tbl[i].w, tbl[i].d, tbl[i].ph);

    // Night mode raised during green[1], dropped mid-flash.
    seg("n_rst",  1,1,0,0, 1, 3'b111,3'b000,3'b000,0,2,0);
    seg("n_ar",   0,1,0,0, 1, 3'b111,3'b000,3'b000,0,2,0);
    seg("n_g0",   0,1,0,0, 8, 3'b110,3'b000,3'b001,0,0,1);
    seg("n_y0",   0,1,0,0, 3, 3'b110,3'b001,3'b000,0,0,2);
    seg("n_ar0",  0,1,0,0, 2, 3'b111,3'b000,3'b000,0,0,0);
    seg("n_g1a",  0,1,0,0, 1, 3'b101,3'b000,3'b010,0,1,1);
    seg("n_g1b",  0,1,1,0, 7, 3'b101,3'b000,3'b010,0,1,1);
    seg("n_y1",   0,1,1,0, 3, 3'b101,3'b010,3'b000,0,1,2);
    seg("n_ar1",  0,1,1,0, 2, 3'b111,3'b000,3'b000,0,1,0);
    seg("fl_on",  0,1,1,0, 2, 3'b000,3'b111,3'b000,0,1,4);
    seg("fl_off", 0,1,1,0, 2, 3'b000,3'b000,3'b000,0,1,4);
    seg("fl_on2", 0,1,1,0, 1, 3'b000,3'b111,3'b000,0,1,4);
    seg("fl_last",0,1,0,0, 1, 3'b000,3'b111,3'b000,0,1,4);
    seg("fl_ar",  0,1,0,0, 2, 3'b111,3'b000,3'b000,0,1,0);
    seg("fl_g2",  0,1,0,0, 1, 3'b011,3'b000,3'b100,0,2,1);

    // Enable hold during yellow.
    seg("e_g2",   0,1,0,0, 7, 3'b011,3'b000,3'b100,0,2,1);
    seg("e_y",    0,1,0,0, 2, 3'b011,3'b100,3'b000,0,2,2);
    seg("e_hold", 0,0,0,0, 5, 3'b011,3'b100,3'b000,0,2,2);
    seg("e_ylast",0,1,0,0, 1, 3'b011,3'b100,3'b000,0,2,2);
    seg("e_ar",   0,1,0,0, 1, 3'b111,3'b000,3'b000,0,2,0);

    // Reset in the middle of WALK.
    seg("rw_req", 0,1,0,1, 1, 3'b111,3'b000,3'b000,0,2,0);
    seg("rw_walk",0,1,0,0, 2, 3'b111,3'b000,3'b000,1,2,3);
    seg("rw_rst", 1,1,0,0, 1, 3'b111,3'b000,3'b000,0,2,0);
    seg("rw_ar",  0,1,0,0, 1, 3'b111,3'b000,3'b000,0,2,0);
    seg("rw_g0",  0,1,0,0, 8, 3'b110,3'b000,3'b001,0,0,1);
    seg("rw_y0",  0,1,0,0, 1, 3'b110,3'b001,3'b000,0,0,2);

    // Request coinciding with WALK entry keeps pending set.
    seg("sc_rst", 1,1,0,0, 1, 3'b111,3'b000,3'b000,0,2,0);
    seg("sc_ar",  0,1,0,1, 1, 3'b111,3'b000,3'b000,0,2,0);
    seg("sc_win", 0,1,0,1, 1, 3'b111,3'b000,3'b000,1,2,3);
    seg("sc_walk",0,1,0,0, 3, 3'b111,3'b000,3'b000,1,2,3);
    seg("sc_gcut",0,1,0,0, 3, 3'b110,3'b000,3'b001,0,0,1);
    seg("sc_y",   0,1,0,0, 3, 3'b110,3'b001,3'b000,0,0,2);
    seg("sc_ar2", 0,1,0,0, 2, 3'b111,3'b000,3'b000,0,0,0);
    seg("sc_wlk2",0,1,0,0, 4, 3'b111,3'b000,3'b000,1,0,3);
    seg("sc_g1",  0,1,0,0, 1, 3'b101,3'b000,3'b010,0,1,1);

    // Randomized run against the reference model.
    begin
      bit r_i, e_i, n_i, p_i;
      logic [14:0] exp;
      n_i = 0;
      for (int c = 0; c < 3000; c++) begin
        r_i = (c == 0) || ($urandom_range(199) == 0);
        e_i = ($urandom_range(7) != 0);
        if ($urandom_range(39) == 0) n_i = !n_i;
        p_i = ($urandom_range(19) == 0);
        rst = r_i; enable = e_i; night_mode = n_i; ped_req = p_i;
        @(posedge clk);
        model_step(r_i, e_i, n_i, p_i);
        #1;
        exp = model_obs();
        n_chk++;
        if (obs !== exp) begin
          n_fail++;
          $display("FAIL rand cyc%0d: got %b want %b (r,y,g,w,dir,ph)", c, obs, exp);
        end
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/traffic_light_ctrl.md
# traffic_light_ctrl

Parametrised multi-direction traffic-light controller. It supersedes the fixed three-light sequencer. It cycles green → yellow → all-red through NUM_DIRS approaches in round-robin order, and adds a latched pedestrian request with an early green cut-off and a walk phase. It also has a flashing-yellow night mode and a run/hold enable. It sits directly behind the board's lamp drivers and has one clock domain.

## Interface
- NUM_DIRS, 2: number of approaches (≥2); DIR_W = $clog2(NUM_DIRS).
- CNT_W, 26: phase counter width; must hold max(T_*)−1.
- T_GREEN, 50_000_000: green duration (cycles).
- T_GREEN_MIN, 15_000_000: minimum green before a pedestrian cut-off; 1 ≤ T_GREEN_MIN ≤ T_GREEN.
- T_YELLOW, 25_000_000: yellow duration.
- T_ALLRED, 5_000_000: all-red clearance duration.
- T_WALK, 25_000_000: pedestrian walk duration.
- T_FLASH, 25_000_000: night-mode half-period.

Ports:
- clk, in, 1: clock. One clock; reset is synchronous and active-high.
- rst, in, 1: synchronous active-high reset.
- enable, in, 1: 1 = run; 0 = freeze state and counter.
- night_mode, in, 1: request flashing-yellow operation.
- ped_req, in, 1: pedestrian request; a pulse of any width.
- red, out, NUM_DIRS: per-direction red lamps.
- yellow, out, NUM_DIRS: per-direction yellow lamps.
- green, out, NUM_DIRS: per-direction green lamps.
- walk, out, 1: pedestrian walk lamp.
- cur_dir, out, DIR_W: direction currently or last served.
- phase, out, 3: current phase code.

## Operation
- Phases: ALLRED, GREEN, YELLOW, WALK, FLASH. The up-counter cnt restarts at 0 on every phase entry. A phase ends in the cycle where cnt == T_x−1.
- ALLRED: red all 1s. At its end, the next phase is chosen by priority night_mode > ped_pending > GREEN. GREEN starts with cur_dir ← cur_dir+1, wrapping NUM_DIRS−1 → 0.
- GREEN: green[cur_dir]=1, red on all other directions. Exits to YELLOW at cnt == T_GREEN−1, or early when ped_pending and cnt ≥ T_GREEN_MIN−1.
- YELLOW: yellow[cur_dir]=1, other directions red. Exits to ALLRED.
- WALK: all red, walk=1. Exits directly to GREEN of cur_dir+1.
- FLASH: red=0, green=0. yellow = all 1s or all 0s per flash_on; flash_on is 1 on entry and toggles at each T_FLASH boundary. At a boundary with night_mode=0, exit to ALLRED with cur_dir unchanged.
- ped_pending is set the cycle after ped_req=1 and cleared on entry to WALK. Set beats clear when both occur in the same cycle.
- enable=0: state, cnt and flash_on hold, and outputs hold. ped_pending still latches requests.
- Outside FLASH, exactly one of red/yellow/green is set for each direction.

## Timing
- Reset values: phase=ALLRED, cnt=0, cur_dir=NUM_DIRS−1, ped_pending=0, flash_on=0. Outputs: red all 1s, yellow=0, green=0, walk=0.
- Outputs are a combinational decode of registered state, so they change in the same cycle as phase.
- Durations count enabled cycles only. GREEN lasts exactly T_GREEN cycles, or max(T_GREEN_MIN, request latch cycle + 1) when cut short.
- night_mode is sampled only at the end of ALLRED and at FLASH boundaries.
- Reset asserted mid-phase returns every register to its reset value on the next edge.

## Structure
- Package traffic_pkg holds the phase codes: PH_ALLRED=0, PH_GREEN=1, PH_YELLOW=2, PH_WALK=3, PH_FLASH=4.
- Sub-module phase_timer holds the CNT_W up-counter. Inputs: clear, enable. Output: a terminal-compare against a runtime limit.
- The top level contains the FSM, the ped_pending latch, flash_on and the output decode.

## Test plan
All scenarios use NUM_DIRS=3, T_GREEN=8, T_GREEN_MIN=3, T_YELLOW=3, T_ALLRED=2, T_WALK=4, T_FLASH=2.
- Release reset: red=111 for 2 cycles, then green=001 ×8, yellow=001 ×3, red=111 ×2, green=010. The sequence wraps from direction 2 back to green=001.
- ped_req for 1 cycle at green[0] cnt=1: green lasts 3, yellow 3, all-red 2, walk=1 ×4, then green=010 and ped_pending=0.
- night_mode=1 during green[1]: the normal green, yellow and all-red complete, then yellow=111 ×2 and 000 ×2 alternate. Drop night_mode: the current half-period finishes, then all-red 2, then green=100.
- enable=0 for 5 cycles at yellow cnt=1: outputs are frozen, and yellow spans 3 enabled cycles in total.
- rst pulse mid-WALK: the next cycle shows red=111, walk=0, cur_dir=2 and ped_pending=0.
- ped_req in the same cycle as WALK entry: pending stays 1. The next green is cut to 3 cycles, followed by a second WALK.
